detect_run_reporter: RTL
========================

DETECT_RUN_REPORTER -- requirements
Module: detect_run_reporter

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of run-length and event counters.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port z  input  1  detection output of the upstream sequence detector, sampled at posedge clk.
REQ-005 SHALL have port clr  input  1  synchronous clear of statistics (overflow, evt_count).
REQ-006 SHALL have port busy  output  1  high while a run of z=1 is being measured (state RUN or SAT).
REQ-007 SHALL have port rpt_valid  output  1  report record available.
REQ-008 SHALL have port rpt_ready  input  1  consumer accepts record.
REQ-009 SHALL have port rpt_len  output  CNT_W  run length in cycles of the head record.
REQ-010 SHALL have port rpt_sat  output  1  head record length saturated.
REQ-011 SHALL have port overflow  output  1  sticky; a record was dropped.
REQ-012 SHALL have port evt_count  output  CNT_W  total runs completed (present only with DRR_EVT_CNT_EN).

Function
REQ-013 SHALL implement FSM states IDLE, RUN, SAT; reset state IDLE.
REQ-014 IDLE: z=1 -> RUN, len=1; z=0 -> stay IDLE, len unchanged.
REQ-015 RUN: z=1 and len<2^CNT_W-1 -> len+1; z=1 and len+1 reaches 2^CNT_W-1 -> SAT with len=2^CNT_W-1.
REQ-016 SAT: z=1 -> stay, len held at 2^CNT_W-1 (no wrap).
REQ-017 RUN or SAT with z=0 -> push record {len, sat=(state==SAT)}, -> IDLE.
REQ-018 Records SHALL pass through a 2-entry FIFO; rpt_valid=1 iff FIFO non-empty; rpt_len/rpt_sat show head entry.
REQ-019 Record pushed at posedge N SHALL be visible (rpt_valid=1 if FIFO was empty) after posedge N, i.e. one cycle after z first sampled 0.
REQ-020 Pop SHALL occur on posedge with rpt_valid&&rpt_ready; head SHALL NOT change while rpt_valid=1 and rpt_ready=0.
REQ-021 Simultaneous push and pop SHALL be accepted in any occupancy, including full.
REQ-022 Push while full without pop SHALL drop the new record, retain both stored entries, set overflow=1.
REQ-023 overflow SHALL remain 1 until rst or clr; clr and a new drop in the same cycle SHALL leave overflow=1.
REQ-024 clr SHALL NOT affect FSM, len, or FIFO contents.
REQ-025 busy SHALL equal (state!=IDLE), registered.

Reset
REQ-026 rst SHALL set state=IDLE, len=0, FIFO empty (rpt_valid=0), rpt_len=0, rpt_sat=0, overflow=0, evt_count=0, busy=0.
REQ-027 rst asserted mid-run SHALL discard the run with no record pushed; rst has priority over clr, z, rpt_ready.

Configuration
REQ-028 Macro DRR_EVT_CNT_EN defined: evt_count port exists, increments by 1 on every completed run (including dropped records), saturates at 2^CNT_W-1, cleared by rst or clr (clr wins over increment).
REQ-029 Macro DRR_EVT_CNT_EN undefined: evt_count port and its register are absent; all other behaviour identical.

Structure
REQ-030 Package drr_pkg SHALL hold the FSM state enum (IDLE, RUN, SAT), the record struct {len, sat}, and the default CNT_W constant.
REQ-031 The 2-entry FIFO SHALL be a sub-module named drr_rpt_fifo2, parameterised on record width, exposing push/full/pop/empty/overflow-drop.

Verification
REQ-032 After rst, z=1 for 3 cycles then 0, rpt_ready=1 -> one record rpt_len=3, rpt_sat=0, rpt_valid high exactly 1 cycle.
REQ-033 CNT_W=4, z=1 for 20 cycles then 0 -> record rpt_len=15, rpt_sat=1, busy high 20 cycles.
REQ-034 rpt_ready=0, three runs of lengths 1,2,4 -> records 1,2 held, third dropped, overflow=1; then rpt_ready=1 -> pops 1 then 2, overflow stays 1 until clr.
REQ-035 FIFO full, run ends in same cycle as pop -> new record accepted, overflow stays 0, order preserved.
REQ-036 rst asserted at cycle 2 of a 5-cycle run -> no record, all outputs reset values next cycle.
REQ-037 With DRR_EVT_CNT_EN, four runs (one dropped) -> evt_count=4; clr -> evt_count=0 next cycle.

Source files
------------

// File: rtl/drr_pkg.sv
// rtl/drr_pkg.sv - shared types and constants for the detect-run reporter
package drr_pkg;

    // Default width of the run-length and event counters.
    localparam int DRR_CNT_W = 8;

    // Run-measurement FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SAT  = 2'd2
    } drr_state_e;

    // One report record at the default counter width: {len, sat}.
    typedef struct packed {
        logic [DRR_CNT_W-1:0] len;
        logic                 sat;
    } drr_rec_t;

    // Packed record width for a given counter width (len bits plus sat flag).
    function automatic int drr_rec_w(input int cnt_w);
        return cnt_w + 1;
    endfunction

endpackage

// File: rtl/drr_rpt_fifo2.sv
// rtl/drr_rpt_fifo2.sv - two-entry record FIFO that drops new data when full
module drr_rpt_fifo2 #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic         full,
    input  logic         pop,
    output logic         empty,
    output logic [W-1:0] head
);

    logic [W-1:0] mem0;
    logic [W-1:0] mem1;
    logic [1:0]   count;
    logic         do_pop;
    logic         do_push;

    // A push into a full FIFO is only taken when a pop frees the head slot in
    // the same cycle; otherwise the incoming record is discarded.
    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);

    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);
    assign head  = mem0;

    // Storage and occupancy; mem0 is always the head entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem0  <= '0;
            mem1  <= '0;
            count <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b11: begin
                    if (count == 2'd1) begin
                        mem0 <= push_data;
                    end else begin
                        mem0 <= mem1;
                        mem1 <= push_data;
                    end
                end
                2'b01: begin
                    mem0  <= mem1;
                    count <= count - 2'd1;
                end
                2'b10: begin
                    if (count == 2'd0) begin
                        mem0 <= push_data;
                    end else begin
                        mem1 <= push_data;
                    end
                    count <= count + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/detect_run_reporter.sv
// rtl/detect_run_reporter.sv - measures runs of z=1 and queues length reports (option: DRR_EVT_CNT_EN)
module detect_run_reporter
    import drr_pkg::*;
#(
    parameter int CNT_W = DRR_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             z,
    input  logic             clr,
    output logic             busy,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [CNT_W-1:0] rpt_len,
    output logic             rpt_sat,
    output logic             overflow
`ifdef DRR_EVT_CNT_EN
    ,
    output logic [CNT_W-1:0] evt_count
`endif
);

    localparam int              REC_W   = drr_rec_w(CNT_W);
    localparam logic [CNT_W-1:0] LEN_MAX = '1;
    localparam logic [CNT_W-1:0] LEN_ONE = CNT_W'(1);

    drr_state_e       state;
    drr_state_e       next_state;
    logic [CNT_W-1:0] len;
    logic [CNT_W-1:0] next_len;
    logic             rec_push;
    logic [REC_W-1:0] rec_data;
    logic [REC_W-1:0] fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             rpt_pop;
    logic             rec_lost;

    // State, length and busy registers; busy tracks the next state so it is
    // registered yet always equals (state != IDLE).
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            len   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= next_state;
            len   <= next_len;
            busy  <= (next_state != IDLE);
        end
    end

    // Run measurement: count while z is high, stick at the maximum, and emit a
    // record on the first cycle z is seen low again.
    always_comb begin
        next_state = state;
        next_len   = len;
        rec_push   = 1'b0;
        case (state)
            IDLE: begin
                if (z) begin
                    next_state = RUN;
                    next_len   = LEN_ONE;
                end
            end
            RUN: begin
                if (z) begin
                    if (len == (LEN_MAX - LEN_ONE)) begin
                        next_state = SAT;
                        next_len   = LEN_MAX;
                    end else begin
                        next_len = len + LEN_ONE;
                    end
                end else begin
                    rec_push   = 1'b1;
                    next_state = IDLE;
                end
            end
            SAT: begin
                if (!z) begin
                    rec_push   = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign rec_data  = {len, (state == SAT)};
    assign rpt_valid = !fifo_empty;
    assign rpt_pop   = rpt_valid && rpt_ready;
    assign rpt_len   = fifo_head[REC_W-1:1];
    assign rpt_sat   = fifo_head[0];
    assign rec_lost  = rec_push && fifo_full && !rpt_pop;

    drr_rpt_fifo2 #(
        .W(REC_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (rec_push),
        .push_data(rec_data),
        .full     (fifo_full),
        .pop      (rpt_pop),
        .empty    (fifo_empty),
        .head     (fifo_head)
    );

    // Sticky overflow: a drop in the same cycle as clr still leaves it set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (rec_lost) begin
            overflow <= 1'b1;
        end else if (clr) begin
            overflow <= 1'b0;
        end
    end

`ifdef DRR_EVT_CNT_EN
    // Completed-run counter, dropped records included; saturates, clr wins.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            evt_count <= '0;
        end else if (rec_push && (evt_count != LEN_MAX)) begin
            evt_count <= evt_count + LEN_ONE;
        end
    end
`endif

endmodule
